hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard controller driving the IF/ID register's WriteEnable, the PC write enable, the IF/ID flush and the ID/EX and EX/MEM bubble/hold controls.

---
 rtl/hazard_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: load-use and branch-operand stalls, multi-cycle
// EX freeze sequencing, wrong-path IF/ID flush and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MC_LATENCY = 4,
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             Branch_ID,
   input  logic             BranchTaken,
   input  logic             IDEX_MemRead,
   input  logic             IDEX_RegWrite,
   input  logic [4:0]       IDEX_WriteReg,
   input  logic             EXMEM_MemRead,
   input  logic [4:0]       EXMEM_WriteReg,
   input  logic             MC_Start,
   output logic             PCWrite,
   output logic             IFID_WriteEnable,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic             IDEX_Hold,
   output logic             EXMEM_Bubble,
   output logic             MC_Busy,
   output logic [CNT_W-1:0] StallCount
);

   localparam int MC_W = $clog2(MC_LATENCY) + 1;
   localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LATENCY - 1);
   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MC_WAIT = 1'b1;

   logic [0:0]      state;
   logic [MC_W-1:0] mc_cnt;
   logic            load_use;
   logic            br_ex;
   logic            br_mem;
   logic            data_stall;
   logic            mc_freeze;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic uses_rt);
      return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

   // Hazard detection for the instruction sitting in ID.
   always_comb begin
      load_use   = IDEX_MemRead & src_match(IDEX_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
      br_ex      = Branch_ID & IDEX_RegWrite & src_match(IDEX_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
      br_mem     = Branch_ID & EXMEM_MemRead & src_match(EXMEM_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
      data_stall = load_use | br_ex | br_mem;
      mc_freeze  = (state == MC_WAIT) | ((state == RUN) & MC_Start);
   end

   // Pipeline control outputs; freeze outranks data stalls, which outrank the flush.
   always_comb begin
      PCWrite          = 1'b1;
      IFID_WriteEnable = 1'b1;
      IFID_Flush       = 1'b0;
      IDEX_Bubble      = 1'b0;
      IDEX_Hold        = 1'b0;
      EXMEM_Bubble     = 1'b0;
      MC_Busy          = 1'b0;
      if (Reset) begin
         PCWrite          = 1'b1;
         IFID_WriteEnable = 1'b1;
      end else if (mc_freeze) begin
         PCWrite          = 1'b0;
         IFID_WriteEnable = 1'b0;
         IDEX_Hold        = 1'b1;
         EXMEM_Bubble     = 1'b1;
         MC_Busy          = 1'b1;
      end else if (data_stall) begin
         PCWrite          = 1'b0;
         IFID_WriteEnable = 1'b0;
         IDEX_Bubble      = 1'b1;
      end else if ((DELAY_SLOT == 0) && BranchTaken) begin
         IFID_Flush       = 1'b1;
      end else begin
         IFID_Flush       = 1'b0;
      end
   end

   // Multi-cycle sequencer: mc_cnt counts the freeze cycles still to come after this one.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= RUN;
         mc_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (MC_Start && (MC_LATENCY > 1)) begin
                  state  <= MC_WAIT;
                  mc_cnt <= MC_LOAD;
               end else begin
                  state  <= RUN;
                  mc_cnt <= '0;
               end
            end
            MC_WAIT: begin
               if (mc_cnt <= MC_W'(1)) begin
                  state  <= RUN;
                  mc_cnt <= '0;
               end else begin
                  state  <= MC_WAIT;
                  mc_cnt <= mc_cnt - MC_W'(1);
               end
            end
            default: begin
               state  <= RUN;
               mc_cnt <= '0;
            end
         endcase
      end
   end

   // Performance counter of cycles in which the PC was held, saturating at all-ones.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         StallCount <= '0;
      end else if (!PCWrite && (StallCount != {CNT_W{1'b1}})) begin
         StallCount <= StallCount + CNT_W'(1);
      end else begin
         StallCount <= StallCount;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (delay-slot/4-cycle and flush/1-cycle/3-bit counter)
// driven with directed and random stimulus and compared to a cycle-level reference model.
module tb_hazard_stall_ctrl;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [4:0] IFID_Rs, IFID_Rt, IDEX_WriteReg, EXMEM_WriteReg;
   logic       IFID_UsesRt, Branch_ID, BranchTaken, IDEX_MemRead, IDEX_RegWrite;
   logic       EXMEM_MemRead, MC_Start;

   logic [6:0]  obs0, obs1;
   logic [31:0] sc0;
   logic [2:0]  sc1;

   int checks = 0;
   int errors = 0;

   // Reference state: remaining freeze cycles and stall count, per instance
   int     lat[2]  = '{4, 1};
   int     ds[2]   = '{1, 0};
   longint cmax[2] = '{64'hFFFF_FFFF, 64'd7};
   int     frz[2];
   longint cnt[2];

   always #5 Clock = ~Clock;

   hazard_stall_ctrl #(.MC_LATENCY(4), .DELAY_SLOT(1), .CNT_W(32)) dut0 (
      .Clock(Clock), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
      .IFID_UsesRt(IFID_UsesRt), .Branch_ID(Branch_ID), .BranchTaken(BranchTaken),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WriteReg(IDEX_WriteReg),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WriteReg(EXMEM_WriteReg), .MC_Start(MC_Start),
      .PCWrite(obs0[6]), .IFID_WriteEnable(obs0[5]), .IFID_Flush(obs0[4]), .IDEX_Bubble(obs0[3]),
      .IDEX_Hold(obs0[2]), .EXMEM_Bubble(obs0[1]), .MC_Busy(obs0[0]), .StallCount(sc0));

   hazard_stall_ctrl #(.MC_LATENCY(1), .DELAY_SLOT(0), .CNT_W(3)) dut1 (
      .Clock(Clock), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
      .IFID_UsesRt(IFID_UsesRt), .Branch_ID(Branch_ID), .BranchTaken(BranchTaken),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WriteReg(IDEX_WriteReg),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WriteReg(EXMEM_WriteReg), .MC_Start(MC_Start),
      .PCWrite(obs1[6]), .IFID_WriteEnable(obs1[5]), .IFID_Flush(obs1[4]), .IDEX_Bubble(obs1[3]),
      .IDEX_Hold(obs1[2]), .EXMEM_Bubble(obs1[1]), .MC_Busy(obs1[0]), .StallCount(sc1));

   function automatic bit reads(input logic [4:0] r);
      return (r != 5'd0) && ((r == IFID_Rs) || (IFID_UsesRt && (r == IFID_Rt)));
   endfunction

   // Expected {PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Bubble, IDEX_Hold, EXMEM_Bubble, MC_Busy}
   function automatic logic [6:0] expect_out(input int k);
      bit freeze, stall;
      freeze = (frz[k] > 0) || MC_Start;
      stall  = (IDEX_MemRead && reads(IDEX_WriteReg)) ||
               (Branch_ID && IDEX_RegWrite && reads(IDEX_WriteReg)) ||
               (Branch_ID && EXMEM_MemRead && reads(EXMEM_WriteReg));
      if (Reset)                       return 7'b1100000;
      if (freeze)                      return 7'b0000111;
      if (stall)                       return 7'b0001000;
      if ((ds[k] == 0) && BranchTaken) return 7'b1110000;
      return 7'b1100000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic set_idle();
      Reset = 1'b0; IFID_Rs = 5'd1; IFID_Rt = 5'd2; IFID_UsesRt = 1'b0; Branch_ID = 1'b0;
      BranchTaken = 1'b0; IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_WriteReg = 5'd0;
      EXMEM_MemRead = 1'b0; EXMEM_WriteReg = 5'd0; MC_Start = 1'b0;
   endtask

   // Inputs already applied in the low phase: check, advance the model, move to next negedge
   task automatic cycle(input string tag);
      logic [6:0] e;
      #1;
      chk({tag, "_out0"}, 64'(obs0), 64'(expect_out(0)));
      chk({tag, "_out1"}, 64'(obs1), 64'(expect_out(1)));
      chk({tag, "_cnt0"}, 64'(sc0), 64'(cnt[0]));
      chk({tag, "_cnt1"}, 64'(sc1), 64'(cnt[1]));
      for (int k = 0; k < 2; k++) begin
         e = expect_out(k);
         if (Reset) begin
            frz[k] = 0;
            cnt[k] = 0;
         end else begin
            if (!e[6] && (cnt[k] < cmax[k])) cnt[k] = cnt[k] + 1;
            if (frz[k] > 0)    frz[k] = frz[k] - 1;
            else if (MC_Start) frz[k] = lat[k] - 1;
         end
      end
      @(negedge Clock);
   endtask

   initial begin
      frz = '{0, 0};
      cnt = '{0, 0};
      set_idle();
      @(negedge Clock);
      // Reset with hazards and MC_Start present: outputs must stay at default
      Reset = 1'b1; MC_Start = 1'b1; IDEX_MemRead = 1'b1; IDEX_WriteReg = 5'd1; BranchTaken = 1'b1;
      cycle("reset");
      set_idle();
      chk("reset_count", 64'(sc0), 64'd0);
      // Load-use on rs
      IDEX_MemRead = 1'b1; IDEX_WriteReg = 5'd5; IFID_Rs = 5'd5;
      cycle("loaduse");
      set_idle();
      cycle("loaduse_after");
      chk("loaduse_count", 64'(sc0), 64'd1);
      // Register zero and unused rt never stall
      IDEX_MemRead = 1'b1; IDEX_WriteReg = 5'd0; IFID_Rs = 5'd0;
      cycle("reg0");
      IDEX_WriteReg = 5'd5; IFID_Rs = 5'd1; IFID_Rt = 5'd5; IFID_UsesRt = 1'b0;
      cycle("rt_unused");
      IFID_UsesRt = 1'b1;
      cycle("rt_used");
      set_idle();
      // lw r3 followed by a branch on r3: BrEX then BrMEM, then proceeds
      Branch_ID = 1'b1; IFID_Rs = 5'd3; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_WriteReg = 5'd3;
      cycle("br_ex");
      IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_WriteReg = 5'd0;
      EXMEM_MemRead = 1'b1; EXMEM_WriteReg = 5'd3;
      cycle("br_mem");
      EXMEM_MemRead = 1'b0; EXMEM_WriteReg = 5'd0;
      cycle("br_go");
      set_idle();
      // Multi-cycle op with a second start mid-wait
      MC_Start = 1'b1;
      cycle("mc0");
      MC_Start = 1'b0;
      cycle("mc1");
      MC_Start = 1'b1;
      cycle("mc2");
      MC_Start = 1'b0;
      cycle("mc3");
      cycle("mc4");
      cycle("mc5");
      // Taken branch, alone and with a concurrent load-use
      BranchTaken = 1'b1;
      cycle("flush");
      IDEX_MemRead = 1'b1; IDEX_WriteReg = 5'd1;
      cycle("flush_stall");
      set_idle();
      // Reset in the second MC_WAIT cycle
      MC_Start = 1'b1;
      cycle("mcr0");
      MC_Start = 1'b0;
      cycle("mcr1");
      Reset = 1'b1;
      cycle("mcr2");
      Reset = 1'b0;
      cycle("mcr3");
      chk("mcr_count", 64'(sc0), 64'd0);
      chk("mcr_pcwrite", 64'(obs0[6]), 64'd1);
      // Random traffic with small register numbers so matches are frequent
      for (int i = 0; i < 600; i++) begin
         Reset          = ($urandom_range(0, 59) == 0);
         IFID_Rs        = 5'($urandom_range(0, 5));
         IFID_Rt        = 5'($urandom_range(0, 5));
         IFID_UsesRt    = 1'($urandom_range(0, 1));
         Branch_ID      = 1'($urandom_range(0, 1));
         BranchTaken    = 1'($urandom_range(0, 1));
         IDEX_MemRead   = ($urandom_range(0, 3) == 0);
         IDEX_RegWrite  = 1'($urandom_range(0, 1));
         IDEX_WriteReg  = 5'($urandom_range(0, 5));
         EXMEM_MemRead  = ($urandom_range(0, 3) == 0);
         EXMEM_WriteReg = 5'($urandom_range(0, 5));
         MC_Start       = ($urandom_range(0, 9) == 0);
         cycle("rand");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
